// File: rtl/cpu_pkg.sv
// Shared types and widths for the ID/EX operand stage.
// Holds the ALU op enum, the ID/EX bundle and a register hit helper.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101,
    ALU_DEF = 3'b111
  } alu_ctrl_t;

  typedef struct packed {
    logic                  valid;
    alu_ctrl_t             alu_ctrl;
    logic                  alu_src;
    logic                  mem_read;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
  } id_ex_t;

  // x0 never counts as a producer
  function automatic logic rd_hit(
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-operand bypass select: EX/MEM, then MEM/WB, then latched data.
// Instantiated once for rs1 and once for rs2.
module fwd_mux #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic                  i_exm_we,
  input  logic [REG_ADDR_W-1:0] i_exm_rd,
  input  logic [DATA_WIDTH-1:0] i_exm_data,
  input  logic                  i_mwb_we,
  input  logic [REG_ADDR_W-1:0] i_mwb_rd,
  input  logic [DATA_WIDTH-1:0] i_mwb_data,
  output logic [DATA_WIDTH-1:0] o_data
);
  import cpu_pkg::*;

  logic w_exm_hit;
  logic w_mwb_sel;

  assign w_exm_hit = i_exm_we & rd_hit(i_exm_rd, i_rs);
  assign w_mwb_sel = i_mwb_we & rd_hit(i_mwb_rd, i_rs)
                   & ~w_exm_hit;

  // Youngest producer wins; selects are made one-hot above
  always_comb begin
    o_data = i_rs_data;
    unique case (1'b1)
      w_exm_hit: o_data = i_exm_data;
      w_mwb_sel: o_data = i_mwb_data;
      default:   o_data = i_rs_data;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register, operand bypass and load-use stall for the ALU.
// Macro ALU_FORWARD_EN enables bypassing; otherwise RAW hazards stall.
module alu_operand_stage #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [2:0]            id_alu_control,
  input  logic                  id_alu_src,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic [DATA_WIDTH-1:0] mwb_result,
  output logic                  ex_valid,
  output logic [2:0]            ex_alu_control,
  output logic [DATA_WIDTH-1:0] ex_alu_op1,
  output logic [DATA_WIDTH-1:0] ex_alu_op2,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  load_use_stall
);
  import cpu_pkg::*;

`ifdef ALU_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  id_ex_t                r_idex;
  id_ex_t                w_dec;
  logic                  w_hit_ex;
  logic                  w_raw_lu;
  logic                  w_raw_extra;
  logic                  w_stall;
  logic [DATA_WIDTH-1:0] w_fwd1;
  logic [DATA_WIDTH-1:0] w_fwd2;

  // Does the decode instruction read the register EX writes
  assign w_hit_ex =
    rd_hit(r_idex.rd, id_rs1_addr) |
    (rd_hit(r_idex.rd, id_rs2_addr) & ~id_alu_src);

  assign w_raw_lu = r_idex.valid & r_idex.mem_read
                  & id_valid & w_hit_ex;

`ifdef ALU_FORWARD_EN
  assign w_raw_extra = 1'b0;
`else
  logic w_hit_exm;
  assign w_hit_exm =
    rd_hit(exm_rd, id_rs1_addr) |
    (rd_hit(exm_rd, id_rs2_addr) & ~id_alu_src);
  assign w_raw_extra = id_valid & (
    (r_idex.valid & r_idex.reg_write & w_hit_ex) |
    (exm_reg_write & w_hit_exm));
`endif

  assign w_stall = (w_raw_lu | w_raw_extra)
                 & ~stall_in & ~flush;
  assign load_use_stall = w_stall;

  // Pack the decode slot; control is qualified by id_valid
  always_comb begin
    w_dec           = '0;
    w_dec.valid     = id_valid;
    w_dec.alu_ctrl  = alu_ctrl_t'(id_alu_control);
    w_dec.alu_src   = id_alu_src;
    w_dec.mem_read  = id_mem_read & id_valid;
    w_dec.reg_write = id_reg_write & id_valid;
    w_dec.rs1       = id_rs1_addr;
    w_dec.rs2       = id_rs2_addr;
    w_dec.rd        = id_rd_addr;
    w_dec.rs1_data  = id_rs1_data;
    w_dec.rs2_data  = id_rs2_data;
    w_dec.imm       = id_imm;
  end

  // Pipeline register: reset > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex <= '0;
    end else if (flush) begin
      r_idex.valid     <= 1'b0;
      r_idex.reg_write <= 1'b0;
      r_idex.mem_read  <= 1'b0;
    end else if (stall_in) begin
      r_idex <= r_idex;
    end else if (w_stall) begin
      r_idex.valid     <= 1'b0;
      r_idex.reg_write <= 1'b0;
      r_idex.mem_read  <= 1'b0;
    end else begin
      r_idex <= w_dec;
    end
  end

  fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .i_rs       (r_idex.rs1),
    .i_rs_data  (r_idex.rs1_data),
    .i_exm_we   (exm_reg_write & FWD_EN),
    .i_exm_rd   (exm_rd),
    .i_exm_data (exm_result),
    .i_mwb_we   (mwb_reg_write & FWD_EN),
    .i_mwb_rd   (mwb_rd),
    .i_mwb_data (mwb_result),
    .o_data     (w_fwd1)
  );

  fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .i_rs       (r_idex.rs2),
    .i_rs_data  (r_idex.rs2_data),
    .i_exm_we   (exm_reg_write & FWD_EN),
    .i_exm_rd   (exm_rd),
    .i_exm_data (exm_result),
    .i_mwb_we   (mwb_reg_write & FWD_EN),
    .i_mwb_rd   (mwb_rd),
    .i_mwb_data (mwb_result),
    .o_data     (w_fwd2)
  );

  assign ex_valid       = r_idex.valid;
  assign ex_alu_control = r_idex.alu_ctrl;
  assign ex_alu_op1     = w_fwd1;
  assign ex_alu_op2     = r_idex.alu_src ? r_idex.imm
                                         : w_fwd2;
  assign ex_store_data  = w_fwd2;
  assign ex_rd          = r_idex.rd;
  assign ex_reg_write   = r_idex.reg_write & r_idex.valid;
  assign ex_mem_read    = r_idex.mem_read & r_idex.valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage.
// Expected values track ALU_FORWARD_EN when defined.
module tb_alu_operand_stage;

`ifdef ALU_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int S_VALID = 0;
  localparam int S_CTRL  = 1;
  localparam int S_OP1   = 2;
  localparam int S_OP2   = 3;
  localparam int S_STORE = 4;
  localparam int S_RD    = 5;
  localparam int S_REGW  = 6;
  localparam int S_MEMR  = 7;
  localparam int S_LUS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_alu_control;
  logic        id_alu_src;
  logic        id_mem_read;
  logic        id_reg_write;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        stall_in;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_result;
  logic        ex_valid;
  logic [2:0]  ex_alu_control;
  logic [31:0] ex_alu_op1;
  logic [31:0] ex_alu_op2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        load_use_stall;

  alu_operand_stage dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_alu_control (id_alu_control),
    .id_alu_src     (id_alu_src),
    .id_mem_read    (id_mem_read),
    .id_reg_write   (id_reg_write),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rd_addr     (id_rd_addr),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .stall_in       (stall_in),
    .flush          (flush),
    .exm_reg_write  (exm_reg_write),
    .exm_rd         (exm_rd),
    .exm_result     (exm_result),
    .mwb_reg_write  (mwb_reg_write),
    .mwb_rd         (mwb_rd),
    .mwb_result     (mwb_result),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_alu_op1     (ex_alu_op1),
    .ex_alu_op2     (ex_alu_op2),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .load_use_stall (load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          at;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_VALID: return {31'd0, ex_valid};
      S_CTRL:  return {29'd0, ex_alu_control};
      S_OP1:   return ex_alu_op1;
      S_OP2:   return ex_alu_op2;
      S_STORE: return ex_store_data;
      S_RD:    return {27'd0, ex_rd};
      S_REGW:  return {31'd0, ex_reg_write};
      S_MEMR:  return {31'd0, ex_mem_read};
      default: return {31'd0, load_use_stall};
    endcase
  endfunction

  task automatic push_exp(input string nm, input int dly,
                          input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.at   = cyc + dly;
    e.sel  = sel;
    e.val  = v;
    q.push_back(e);
  endtask

  // Monitor: retire every expectation due this cycle
  always @(negedge clk) begin
    int i;
    logic [31:0] a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].at == cyc) begin
        a = actual(q[i].sel);
        checks++;
        if (a !== q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h want=%h",
                   q[i].name, cyc, a, q[i].val);
        end
        q.delete(i);
      end else if (q[i].at < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s stale cyc=%0d got=none want=%h",
                 q[i].name, cyc, q[i].val);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [2:0] c,
                     input logic src, input logic mr,
                     input logic rw, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [4:0] ad,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] im);
    id_valid       = v;
    id_alu_control = c;
    id_alu_src     = src;
    id_mem_read    = mr;
    id_reg_write   = rw;
    id_rs1_addr    = a1;
    id_rs2_addr    = a2;
    id_rd_addr     = ad;
    id_rs1_data    = d1;
    id_rs2_data    = d2;
    id_imm         = im;
  endtask

  task automatic exm(input logic we, input logic [4:0] rd,
                     input logic [31:0] d);
    exm_reg_write = we;
    exm_rd        = rd;
    exm_result    = d;
  endtask

  task automatic mwb(input logic we, input logic [4:0] rd,
                     input logic [31:0] d);
    mwb_reg_write = we;
    mwb_rd        = rd;
    mwb_result    = d;
  endtask

  initial begin
    rst = 1'b1;
    stall_in = 1'b0;
    flush = 1'b0;
    dec(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exm(0, 0, 0);
    mwb(0, 0, 0);
    step();
    step();
    // reset state
    push_exp("rst_valid", 0, S_VALID, 0);
    push_exp("rst_ctrl", 0, S_CTRL, 0);
    push_exp("rst_op1", 0, S_OP1, 0);
    push_exp("rst_op2", 0, S_OP2, 0);
    push_exp("rst_regw", 0, S_REGW, 0);
    push_exp("rst_lus", 0, S_LUS, 0);
    rst = 1'b0;

    // ADD x3,x1,x2
    dec(1, 3'b000, 0, 0, 1, 1, 2, 3, 5, 7, 0);
    push_exp("add_lus", 0, S_LUS, 0);
    push_exp("add_valid", 1, S_VALID, 1);
    push_exp("add_ctrl", 1, S_CTRL, 0);
    push_exp("add_op1", 1, S_OP1, 5);
    push_exp("add_op2", 1, S_OP2, 7);
    push_exp("add_rd", 1, S_RD, 3);
    push_exp("add_regw", 1, S_REGW, 1);
    step();

    // AND x9,x4,x0 then hold it under stall_in
    dec(1, 3'b010, 0, 0, 1, 4, 0, 9, 32'h11, 32'h22, 0);
    push_exp("and_lus", 0, S_LUS, 0);
    push_exp("and_ctrl", 1, S_CTRL, 3'b010);
    step();
    id_valid = 1'b0;
    stall_in = 1'b1;
    exm(1, 4, 32'hAA);
    mwb(1, 4, 32'hBB);
    push_exp("fwd_both", 0, S_OP1, FWD ? 32'hAA : 32'h11);
    step();
    exm_reg_write = 1'b0;
    push_exp("fwd_mwb", 0, S_OP1, FWD ? 32'hBB : 32'h11);
    step();
    exm(1, 0, 32'hAA);
    mwb(1, 0, 32'hBB);
    push_exp("x0_op1", 0, S_OP1, 32'h11);
    push_exp("x0_op2", 0, S_OP2, 32'h22);
    push_exp("x0_store", 0, S_STORE, 32'h22);
    push_exp("hold_valid", 0, S_VALID, 1);
    step();
    stall_in = 1'b0;
    exm(0, 0, 0);
    mwb(0, 0, 0);
    push_exp("hold3_valid", 0, S_VALID, 1);
    push_exp("hold3_rd", 0, S_RD, 9);
    push_exp("hold3_ctrl", 0, S_CTRL, 3'b010);

    // LW x6,8(x1) then SUB x7,x6,x1
    dec(1, 3'b000, 1, 1, 1, 1, 0, 6, 32'h100, 0, 8);
    push_exp("lw_lus", 0, S_LUS, 0);
    push_exp("lw_valid", 1, S_VALID, 1);
    push_exp("lw_memr", 1, S_MEMR, 1);
    push_exp("lw_rd", 1, S_RD, 6);
    push_exp("lw_op2", 1, S_OP2, 8);
    step();
    dec(1, 3'b001, 0, 0, 1, 6, 1, 7, 32'h999, 3, 0);
    push_exp("lu_stall", 0, S_LUS, 1);
    push_exp("bub_valid", 1, S_VALID, 0);
    push_exp("bub_regw", 1, S_REGW, 0);
    step();
    exm(1, 6, 32'h108);
    push_exp("exm_lus", 0, S_LUS, FWD ? 0 : 1);
    push_exp("sub_valid", FWD ? 1 : 2, S_VALID, 1);
    push_exp("sub_ctrl", FWD ? 1 : 2, S_CTRL, 3'b001);
    push_exp("sub_op1", FWD ? 1 : 2, S_OP1, 32'h55);
    push_exp("sub_op2", FWD ? 1 : 2, S_OP2, 3);
    step();
    exm(0, 0, 0);
    mwb(1, 6, 32'h55);
    id_rs1_data = 32'h55;
    id_valid = !FWD;
    push_exp("wb_lus", 0, S_LUS, 0);
    step();
    mwb(0, 0, 0);
    id_valid = 1'b0;
    step();

    // OR x10,x2,x3 then flush with stall_in
    dec(1, 3'b011, 0, 0, 1, 2, 3, 10, 32'h0F, 32'hF0, 0);
    push_exp("or_valid", 1, S_VALID, 1);
    push_exp("or_regw", 1, S_REGW, 1);
    push_exp("or_ctrl", 1, S_CTRL, 3'b011);
    step();
    dec(1, 3'b010, 0, 0, 1, 10, 3, 11, 0, 0, 0);
    flush = 1'b1;
    stall_in = 1'b1;
    push_exp("fl_lus", 0, S_LUS, 0);
    push_exp("fl_valid", 1, S_VALID, 0);
    push_exp("fl_regw", 1, S_REGW, 0);
    push_exp("fl_memr", 1, S_MEMR, 0);
    step();
    flush = 1'b0;
    stall_in = 1'b0;

    // ADDI-style with rs2 match on EX/MEM
    dec(1, 3'b000, 1, 0, 1, 13, 14, 12,
        32'h1, 32'h77, 32'hFFFF_FFFC);
    push_exp("imm_lus", 0, S_LUS, 0);
    step();
    id_valid = 1'b0;
    exm(1, 14, 32'hDEAD);
    push_exp("imm_op2", 0, S_OP2, 32'hFFFF_FFFC);
    push_exp("imm_store", 0, S_STORE,
             FWD ? 32'hDEAD : 32'h77);
    push_exp("imm_op1", 0, S_OP1, 32'h1);
    push_exp("imm_valid", 0, S_VALID, 1);
    step();
    exm(0, 0, 0);
    repeat (3) step();

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding front end that directly feeds the execute-stage ALU.
- Latches decoded operands and control.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and requests a decode stall.
- Drives the ALU's 3-bit control and both 32-bit operands.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_alu_control  in  3  ALU op code (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT)
id_alu_src  in  1  1: op2 = immediate, 0: op2 = rs2
id_mem_read  in  1  instruction is a load
id_reg_write  in  1  instruction writes rd
id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W each  register indices
id_rs1_data, id_rs2_data, id_imm  in  DATA_WIDTH each  register file reads / extended immediate
stall_in  in  1  downstream hold; freeze stage contents
flush  in  1  squash latched instruction (branch redirect)
exm_reg_write  in  1  EX/MEM stage writes rd
exm_rd  in  REG_ADDR_W  EX/MEM destination
exm_result  in  DATA_WIDTH  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB stage writes rd
mwb_rd  in  REG_ADDR_W  MEM/WB destination
mwb_result  in  DATA_WIDTH  MEM/WB writeback value
ex_valid  out  1  execute slot valid
ex_alu_control  out  3  to ALU
ex_alu_op1, ex_alu_op2  out  DATA_WIDTH each  to ALU
ex_store_data  out  DATA_WIDTH  forwarded rs2, for stores
ex_rd  out  REG_ADDR_W  latched destination
ex_reg_write, ex_mem_read  out  1 each  latched control, gated by ex_valid
load_use_stall  out  1  combinational; decode must hold PC/IF/ID

Behaviour:
- Reset: all latched fields 0; ex_valid=0; ex_alu_control=000; operands 0; load_use_stall=0.
- Register update priority per edge: rst > flush > stall_in (hold all) > load_use_stall (insert bubble) > load decode fields.
  - Flush: clears ex_valid, ex_reg_write, ex_mem_read. Data fields are don't-care.
  - Flush together with stall_in: flush wins.
- Bubble: ex_valid=0, reg_write=0, mem_read=0. The decode instruction is not consumed.
- Latency: one cycle from decode inputs to EX outputs.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1_addr) | (ex_rd == id_rs2_addr & !id_alu_src)).
  - Forced 0 during stall_in and flush.
- Forwarding is combinational from the latched rs1/rs2 indices, evaluated separately for rs1 and rs2:
  - EX/MEM match (exm_reg_write, exm_rd != 0, exm_rd == rs) selects exm_result.
  - Otherwise MEM/WB match selects mwb_result.
  - Otherwise the latched register data is used.
  - x0 is never forwarded. EX/MEM has priority when both stages match.
- ex_alu_op1 = forwarded rs1.
- ex_alu_op2 = ex_alu_src ? latched imm : forwarded rs2.
- ex_store_data = forwarded rs2 in all cases.
- Outputs are driven even when ex_valid=0. Consumers qualify with ex_valid.

Optional Feature:
ALU_FORWARD_EN
- Defined: forwarding as above.
- Undefined: operands come straight from the latched data. load_use_stall additionally asserts for any valid RAW dependency on the latched EX instruction (ex_reg_write, ex_rd != 0) or on EX/MEM (exm_reg_write, exm_rd != 0). MEM/WB is assumed resolved by register-file write-before-read.

Decomposition:
- Shared package cpu_pkg holds:
  - alu_ctrl_t enum with the five op codes plus default.
  - Widths DATA_WIDTH and REG_ADDR_W.
  - id_ex_t packed struct of latched fields.
- Sub-module fwd_mux: one rs index plus the two stage write ports gives a forwarded value. It is instantiated twice.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → ex_valid=0, ex_alu_op1=ex_alu_op2=0, load_use_stall=0.
- ADD x3,x1,x2 with rs1=5, rs2=7, no hazards → next cycle ex_alu_control=000, op1=5, op2=7, ex_rd=3, ex_valid=1.
- Double forward: latched rs1=x4; exm_rd=4 with exm_result=0xAA and mwb_rd=4 with mwb_result=0xBB → op1=0xAA. Same with exm_reg_write=0 → 0xBB. Same with rd=x0 → latched data.
- Load-use: latched LW x6 followed by decode SUB x7,x6,x1 → load_use_stall=1. Next cycle ex_valid=0 (bubble) and the SUB stays in decode. The following cycle the SUB enters with op1 forwarded from MEM/WB.
- flush and stall_in asserted together with a valid latched instruction → next cycle ex_valid=0, ex_reg_write=0. stall_in alone holds all outputs unchanged for 3 cycles.
- Immediate: alu_src=1, imm=0xFFFFFFFC, rs2 forwarding match present → op2=0xFFFFFFFC and ex_store_data equals the forwarded value.
